// File: rtl/bus_pkg.sv
// Shared constants and helper functions for the multi-drop packet bus port.
package bus_pkg;

  // Default destination-ID field width and the matching broadcast ID.
  localparam int              ID_W_DEF      = 8;
  localparam logic [ID_W_DEF-1:0] BROADCAST_DEF = '1;

  // Destination ID sits in the top id_w bits of a pckg_sz-bit packet.
  // The packet is passed zero-extended to 64 bits so one function serves any width.
  function automatic logic [63:0] get_dest_id(input logic [63:0] pkt,
                                              input int          pckg_sz,
                                              input int          id_w);
    logic [63:0] mask;
    mask = (64'd1 << id_w) - 64'd1;
    return (pkt >> (pckg_sz - id_w)) & mask;
  endfunction

  // Add inc (0..2) to a cnt_w-bit counter, clamping at 2^cnt_w-1 instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                          input logic [1:0]  inc,
                                          input int          cnt_w);
    logic [32:0] max_val;
    logic [32:0] sum;
    max_val = (33'd1 << cnt_w) - 33'd1;
    sum     = {1'b0, cnt} + {31'd0, inc};
    return (sum > max_val) ? max_val[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with occupancy counter.
// Any depth >= 2 is legal: pointers wrap explicitly at DEPTH-1.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             ovf_pulse,
  output logic             udf_pulse
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             do_wr;
  logic             do_rd;

  assign full  = (occ == FULL_OCC);
  assign empty = (occ == '0);

  // A read while full frees the slot the same-edge write lands in.
  assign do_rd     = rd_en && !empty;
  assign do_wr     = wr_en && (!full || rd_en);
  assign ovf_pulse = wr_en && full && !rd_en;
  assign udf_pulse = rd_en && empty;

  // Head is forced to zero while empty so stale storage never leaks out.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage write port.
  // NOTE: the data array is deliberately not reset; occupancy alone decides
  // validity, and leaving it out keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy update; reset empties the FIFO at that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_wr) wr_ptr <= next_ptr(wr_ptr);
      if (do_rd) rd_ptr <= next_ptr(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bus_port_fifo.sv
// Device-side port for the multi-drop packet bus: TX buffer toward the bus,
// ID-filtered RX buffer toward the device, and saturating event counters.
module bus_port_fifo
  import bus_pkg::*;
#(
  parameter int              PCKG_SZ   = 16,
  parameter int              ID_W      = ID_W_DEF,
  parameter logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}},
  parameter int              TX_DEPTH  = 16,
  parameter int              RX_DEPTH  = 16,
  parameter int              CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ID_W-1:0]    my_id,
  input  logic               promisc,
  input  logic               dev_wr_en,
  input  logic [PCKG_SZ-1:0] dev_wr_data,
  output logic               dev_tx_full,
  output logic               pndng,
  output logic [PCKG_SZ-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [PCKG_SZ-1:0] D_push,
  input  logic               dev_rd_en,
  output logic               dev_rd_valid,
  output logic [PCKG_SZ-1:0] dev_rd_data,
  output logic [CNT_W-1:0]   tx_drop_cnt,
  output logic [CNT_W-1:0]   rx_drop_cnt,
  output logic [CNT_W-1:0]   rx_filt_cnt,
  output logic [CNT_W-1:0]   err_cnt
);

  logic            tx_empty;
  logic            tx_ovf;
  logic            tx_udf;
  logic            rx_full;
  logic            rx_empty;
  logic            rx_ovf;
  logic            rx_udf;
  logic [ID_W-1:0] dest_id;
  logic            rx_accept;
  logic            rx_reject;
  logic [1:0]      err_inc;

  // TX: device writes, bus pops.
  sync_fifo_fwft #(.WIDTH(PCKG_SZ), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (dev_wr_en),
    .wr_data   (dev_wr_data),
    .rd_en     (pop),
    .rd_data   (D_pop),
    .full      (dev_tx_full),
    .empty     (tx_empty),
    .ovf_pulse (tx_ovf),
    .udf_pulse (tx_udf)
  );

  assign pndng = !tx_empty;

  // RX address filter: own ID, broadcast, or anything in promiscuous mode.
  assign dest_id   = ID_W'(get_dest_id(64'(D_push), PCKG_SZ, ID_W));
  assign rx_accept = push && (promisc || (dest_id == my_id) || (dest_id == BROADCAST));
  assign rx_reject = push && !rx_accept;

  // RX: bus pushes accepted packets, device reads.
  sync_fifo_fwft #(.WIDTH(PCKG_SZ), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (rx_accept),
    .wr_data   (D_push),
    .rd_en     (dev_rd_en),
    .rd_data   (dev_rd_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .ovf_pulse (rx_ovf),
    .udf_pulse (rx_udf)
  );

  assign dev_rd_valid = !rx_empty;

  // Empty-pop on TX and empty-read on RX in one cycle both count.
  assign err_inc = {1'b0, tx_udf} + {1'b0, rx_udf};

  // Saturating event counters; reset has priority so same-cycle events are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_drop_cnt <= '0;
      rx_drop_cnt <= '0;
      rx_filt_cnt <= '0;
      err_cnt     <= '0;
    end else begin
      tx_drop_cnt <= CNT_W'(sat_inc(32'(tx_drop_cnt), {1'b0, tx_ovf}, CNT_W));
      rx_drop_cnt <= CNT_W'(sat_inc(32'(rx_drop_cnt), {1'b0, rx_ovf}, CNT_W));
      rx_filt_cnt <= CNT_W'(sat_inc(32'(rx_filt_cnt), {1'b0, rx_reject}, CNT_W));
      err_cnt     <= CNT_W'(sat_inc(32'(err_cnt), err_inc, CNT_W));
    end
  end

endmodule
